rx_byte_to_word: RTL and testbench

// Downstream of the OFDM receiver core. Packs the decoded byte stream (byte_out/byte_out_strobe) into
// 64-bit little-endian words and buffers them in a small FIFO. The FIFO feeds the rx interface over a

---
 rtl/rx_byte_to_word.sv | 246 ++++++++++++++++++++++++
 tb/tb_rx_byte_to_word.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_byte_to_word.sv
// Packs decoded receiver bytes into 64-bit little-endian words and queues them,
// together with per-packet terminators, in a small valid/ready output FIFO.
module rx_byte_to_word #(
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pkt_header_valid_strobe,
  input  logic        pkt_header_valid,
  input  logic [15:0] pkt_len,
  input  logic        byte_out_strobe,
  input  logic [7:0]  byte_out,
  input  logic        fcs_out_strobe,
  input  logic        fcs_ok,
  output logic [63:0] m_word_data,
  output logic [7:0]  m_word_keep,
  output logic        m_word_last,
  output logic        m_word_fcs_ok,
  output logic        m_word_err,
  output logic        m_word_valid,
  input  logic        m_word_ready,
  output logic        pkt_ongoing,
  output logic [15:0] drop_count
);

  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam int EW    = 75;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW:0] TWO_C   = (AW+1)'(2);
  localparam logic [AW:0] THREE_C = (AW+1)'(3);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DROP    = 2'd2
  } state_t;

  function automatic logic [7:0] keep_of(input logic [3:0] n);
    keep_of = 8'hFF >> (4'd8 - n);
  endfunction

  function automatic logic [EW-1:0] pack_entry(input logic err, input logic fok, input logic last,
                                               input logic [7:0] keep, input logic [63:0] data);
    pack_entry = {err, fok, last, keep, data};
  endfunction

  localparam logic [EW-1:0] ERR_ENTRY = {1'b1, 1'b0, 1'b1, 8'h00, 64'h0};

  state_t          state_r;
  logic [63:0]     acc_r;
  logic [3:0]      lanes_r;
  logic [15:0]     cnt_r;
  logic [15:0]     len_r;
  logic [15:0]     drop_count_r;
  logic            pkt_ongoing_r;
  logic            valid_r;
  logic [EW-1:0]   mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;

  logic            hdr_acc_s;
  logic            byte_take_s;
  logic            pending_s;
  logic            pop_s;
  logic            drop_now_s;
  logic            drop_inc_s;
  logic [AW:0]     free_s;
  logic [AW:0]     count_n_s;
  logic [1:0]      push_n_s;
  logic [EW-1:0]   e0_s;
  logic [EW-1:0]   e1_s;
  state_t          state_n_s;
  logic [63:0]     acc_n_s;
  logic [63:0]     wacc_s;
  logic [3:0]      lanes_n_s;
  logic [3:0]      wlanes_s;
  logic [15:0]     cnt_n_s;
  logic [15:0]     len_n_s;

  assign hdr_acc_s   = pkt_header_valid_strobe & pkt_header_valid;
  assign byte_take_s = byte_out_strobe & (cnt_r < len_r);
  assign pending_s   = (lanes_r == 4'd8);
  assign free_s      = DEPTH_C - count_r;
  assign pop_s       = valid_r & m_word_ready;
  assign count_n_s   = count_r + (AW+1)'(push_n_s) - (AW+1)'(pop_s);

  // Next packet state and up to two FIFO pushes (a pending full word plus the terminator).
  always_comb begin
    state_n_s  = state_r;
    acc_n_s    = acc_r;
    lanes_n_s  = lanes_r;
    cnt_n_s    = cnt_r;
    len_n_s    = len_r;
    wacc_s     = acc_r;
    wlanes_s   = lanes_r;
    drop_now_s = 1'b0;
    drop_inc_s = 1'b0;
    push_n_s   = 2'd0;
    e0_s       = '0;
    e1_s       = '0;
    if (hdr_acc_s) begin
      if (state_r == IDLE) begin
        if (free_s >= ONE_C) begin
          state_n_s = COLLECT;
          len_n_s   = pkt_len;
          acc_n_s   = 64'h0;
          lanes_n_s = 4'd0;
          cnt_n_s   = 16'd0;
        end else begin
          drop_inc_s = 1'b1;
        end
      end else begin
        // Receiver restarted: close the old packet, and only reopen if the new one keeps a spare slot.
        push_n_s   = 2'd1;
        e0_s       = ERR_ENTRY;
        drop_inc_s = 1'b1;
        if (free_s >= THREE_C) begin
          state_n_s = COLLECT;
          len_n_s   = pkt_len;
          acc_n_s   = 64'h0;
          lanes_n_s = 4'd0;
          cnt_n_s   = 16'd0;
        end else begin
          state_n_s = IDLE;
        end
      end
    end else begin
      case (state_r)
        IDLE: state_n_s = IDLE;
        COLLECT: begin
          if (byte_take_s) begin
            cnt_n_s = cnt_r + 16'd1;
            if (pending_s) begin
              if (free_s >= TWO_C) begin
                push_n_s = 2'd1;
                e0_s     = pack_entry(1'b0, 1'b0, 1'b0, 8'hFF, acc_r);
                wacc_s   = {56'h0, byte_out};
                wlanes_s = 4'd1;
              end else begin
                drop_now_s = 1'b1;
              end
            end else begin
              wacc_s[{lanes_r[2:0], 3'b000} +: 8] = byte_out;
              wlanes_s = lanes_r + 4'd1;
            end
          end else begin
            cnt_n_s = cnt_r;
          end
          if (drop_now_s) begin
            if (fcs_out_strobe) begin
              push_n_s   = 2'd1;
              e0_s       = ERR_ENTRY;
              drop_inc_s = 1'b1;
              state_n_s  = IDLE;
            end else begin
              state_n_s = DROP;
            end
          end else if (fcs_out_strobe) begin
            if (push_n_s == 2'd1) begin
              e1_s     = pack_entry(1'b0, fcs_ok, 1'b1, keep_of(wlanes_s), wacc_s);
              push_n_s = 2'd2;
            end else begin
              e0_s     = pack_entry(1'b0, fcs_ok, 1'b1, keep_of(wlanes_s), wacc_s);
              push_n_s = 2'd1;
            end
            state_n_s = IDLE;
          end else begin
            state_n_s = COLLECT;
          end
          acc_n_s   = wacc_s;
          lanes_n_s = wlanes_s;
        end
        DROP: begin
          if (fcs_out_strobe) begin
            push_n_s   = 2'd1;
            e0_s       = ERR_ENTRY;
            drop_inc_s = 1'b1;
            state_n_s  = IDLE;
          end else begin
            state_n_s = DROP;
          end
        end
        default: state_n_s = IDLE;
      endcase
    end
  end

  // Packet state, accumulator, and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      acc_r         <= 64'h0;
      lanes_r       <= 4'd0;
      cnt_r         <= 16'd0;
      len_r         <= 16'd0;
      drop_count_r  <= 16'd0;
      pkt_ongoing_r <= 1'b0;
    end else begin
      state_r       <= state_n_s;
      acc_r         <= acc_n_s;
      lanes_r       <= lanes_n_s;
      cnt_r         <= cnt_n_s;
      len_r         <= len_n_s;
      pkt_ongoing_r <= (state_n_s == COLLECT) || (state_n_s == DROP);
      if (drop_inc_s && (drop_count_r != 16'hFFFF)) begin
        drop_count_r <= drop_count_r + 16'd1;
      end
    end
  end

  // Output FIFO storage, pointers, and registered head-valid flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (push_n_s != 2'd0) begin
        mem_r[wr_ptr_r] <= e0_s;
      end
      if (push_n_s == 2'd2) begin
        mem_r[wr_ptr_r + AW'(1)] <= e1_s;
      end
      wr_ptr_r <= wr_ptr_r + AW'(push_n_s);
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_n_s;
      valid_r <= (count_n_s != '0);
    end
  end

  assign {m_word_err, m_word_fcs_ok, m_word_last, m_word_keep, m_word_data} = mem_r[rd_ptr_r];
  assign m_word_valid = valid_r;
  assign pkt_ongoing  = pkt_ongoing_r;
  assign drop_count   = drop_count_r;

endmodule

// File: tb/tb_rx_byte_to_word.sv
// Bench for rx_byte_to_word: directed scenarios plus randomized packets, checked
// against a packet-level byte-queue reference model.
module tb_rx_byte_to_word;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pkt_header_valid_strobe = 1'b0;
  logic        pkt_header_valid = 1'b0;
  logic [15:0] pkt_len = 16'd0;
  logic        byte_out_strobe = 1'b0;
  logic [7:0]  byte_out = 8'd0;
  logic        fcs_out_strobe = 1'b0;
  logic        fcs_ok = 1'b0;
  logic [63:0] m_word_data;
  logic [7:0]  m_word_keep;
  logic        m_word_last;
  logic        m_word_fcs_ok;
  logic        m_word_err;
  logic        m_word_valid;
  logic        m_word_ready = 1'b0;
  logic        pkt_ongoing;
  logic [15:0] drop_count;

  always #5 clock = ~clock;

  rx_byte_to_word #(.FIFO_DEPTH_LOG2(2)) dut (
    .clock(clock), .reset(reset),
    .pkt_header_valid_strobe(pkt_header_valid_strobe), .pkt_header_valid(pkt_header_valid),
    .pkt_len(pkt_len), .byte_out_strobe(byte_out_strobe), .byte_out(byte_out),
    .fcs_out_strobe(fcs_out_strobe), .fcs_ok(fcs_ok),
    .m_word_data(m_word_data), .m_word_keep(m_word_keep), .m_word_last(m_word_last),
    .m_word_fcs_ok(m_word_fcs_ok), .m_word_err(m_word_err), .m_word_valid(m_word_valid),
    .m_word_ready(m_word_ready), .pkt_ongoing(pkt_ongoing), .drop_count(drop_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: words are {err, fcs_ok, last, keep[7:0], data[63:0]}
  logic [74:0] mq[$];
  logic [74:0] exp_pop[$];
  logic [74:0] dut_pop[$];
  logic [7:0]  cur[$];
  bit          in_pkt;
  bit          dropping;
  int          mlen;
  int          got;
  int          mdrops;

  function automatic logic [74:0] mk(bit err, bit fok, bit last, logic [7:0] keep, logic [63:0] data);
    return {err, fok, last, keep, data};
  endfunction

  function automatic logic [74:0] word_of(bit last, bit fok);
    logic [63:0] d = 64'h0;
    int n = cur.size();
    for (int i = 0; i < n; i++) d = d | (64'(cur[i]) << (8 * i));
    return mk(1'b0, fok, last, 8'((1 << n) - 1), d);
  endfunction

  task automatic open_pkt(input int len);
    in_pkt = 1; dropping = 0; mlen = len; got = 0; cur.delete();
  endtask

  task automatic drop_inc();
    if (mdrops < 65535) mdrops++;
  endtask

  // One clock cycle: drive inputs, log a DUT pop, advance the model, then clock.
  task automatic step(input bit hs, input bit hv, input int len, input bit bs, input logic [7:0] b,
                      input bit fs, input bit fok, input bit rdy);
    int old;
    int free;
    pkt_header_valid_strobe = hs; pkt_header_valid = hv; pkt_len = 16'(len);
    byte_out_strobe = bs; byte_out = b; fcs_out_strobe = fs; fcs_ok = fok; m_word_ready = rdy;
    if (m_word_valid === 1'b1 && rdy)
      dut_pop.push_back({m_word_err, m_word_fcs_ok, m_word_last, m_word_keep, m_word_data});
    old = mq.size();
    free = DEPTH - old;
    if (hs && hv) begin
      if (!in_pkt) begin
        if (free >= 1) open_pkt(len); else drop_inc();
      end else begin
        mq.push_back(mk(1, 0, 1, 8'h00, 64'h0)); drop_inc();
        if (free - 1 >= 2) open_pkt(len); else in_pkt = 0;
      end
    end else if (in_pkt && dropping) begin
      if (fs) begin mq.push_back(mk(1, 0, 1, 8'h00, 64'h0)); drop_inc(); in_pkt = 0; end
    end else if (in_pkt) begin
      if (bs && got < mlen) begin
        got++;
        if (cur.size() == 8) begin
          if (free >= 2) begin mq.push_back(word_of(0, 0)); cur.delete(); cur.push_back(b); end
          else dropping = 1;
        end else cur.push_back(b);
      end
      if (fs) begin
        if (dropping) begin mq.push_back(mk(1, 0, 1, 8'h00, 64'h0)); drop_inc(); end
        else mq.push_back(word_of(1, fok));
        in_pkt = 0;
      end
    end
    if (old != 0 && rdy) exp_pop.push_back(mq.pop_front());
    @(posedge clock); #1;
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, 8'h00, 0, 0, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (mq.size() != 0 || m_word_valid === 1'b1); i++) idle(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pkt_header_valid_strobe = 0; pkt_header_valid = 0; pkt_len = 16'd0; byte_out_strobe = 0;
    byte_out = 8'd0; fcs_out_strobe = 0; fcs_ok = 0; m_word_ready = 0;
    mq.delete(); exp_pop.delete(); dut_pop.delete(); cur.delete();
    in_pkt = 0; dropping = 0; mdrops = 0; mlen = 0; got = 0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (m_word_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", m_word_valid); end
    tests++; if ({m_word_err, m_word_fcs_ok, m_word_last, m_word_keep, m_word_data} !== 75'h0) begin
      fails++; $display("FAIL reset_word: got %h want 0", {m_word_err, m_word_fcs_ok, m_word_last, m_word_keep, m_word_data}); end
    tests++; if (pkt_ongoing !== 1'b0 || drop_count !== 16'd0) begin
      fails++; $display("FAIL reset_status: ongoing=%b drops=%0d want 0/0", pkt_ongoing, drop_count); end
  endtask

  task automatic test_basic12();
    do_reset();
    step(1, 1, 12, 0, 8'h00, 0, 0, 1);
    tests++; if (pkt_ongoing !== 1'b1) begin fails++; $display("FAIL t1_ongoing: got %b want 1", pkt_ongoing); end
    for (int i = 1; i <= 12; i++) step(0, 0, 0, 1, 8'(i), 0, 0, 1);
    step(0, 0, 0, 0, 8'h00, 1, 1, 1);
    drain();
    tests++; if (dut_pop.size() != 2) begin fails++; $display("FAIL t1_count: got %0d want 2", dut_pop.size()); end
    if (dut_pop.size() >= 2) begin
      tests++; if (dut_pop[0] !== mk(0, 0, 0, 8'hFF, 64'h0807060504030201)) begin
        fails++; $display("FAIL t1_word0: got %h want %h", dut_pop[0], mk(0, 0, 0, 8'hFF, 64'h0807060504030201)); end
      tests++; if (dut_pop[1][31:0] !== 32'h0C0B0A09 || dut_pop[1][74:64] !== {1'b0, 1'b1, 1'b1, 8'h0F}) begin
        fails++; $display("FAIL t1_word1: got %h want ctl=0,1,1,0F low=0C0B0A09", dut_pop[1]); end
    end
  endtask

  task automatic test_len16();
    do_reset();
    step(1, 1, 16, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 8'($urandom), 0, 0, 1);
    step(0, 0, 0, 0, 8'h00, 1, 0, 1);
    drain();
    tests++; if (dut_pop.size() != 2) begin fails++; $display("FAIL t2_count: got %0d want 2", dut_pop.size()); end
    if (dut_pop.size() >= 2) begin
      tests++; if (dut_pop[0][74:64] !== {3'b000, 8'hFF} || dut_pop[1][74:64] !== {3'b001, 8'hFF}) begin
        fails++; $display("FAIL t2_ctl: got %h %h want 0FF 1FF", dut_pop[0][74:64], dut_pop[1][74:64]); end
      tests++; if (dut_pop[0] !== exp_pop[0] || dut_pop[1] !== exp_pop[1]) begin
        fails++; $display("FAIL t2_data: got %h %h want %h %h", dut_pop[0], dut_pop[1], exp_pop[0], exp_pop[1]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1, 1, 64, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 64; i++) step(0, 0, 0, 1, 8'($urandom), 0, 0, 0);
    step(0, 0, 0, 0, 8'h00, 1, 1, 0);
    tests++; if (drop_count !== 16'd1 || m_word_valid !== 1'b1 || mq.size() != 4) begin
      fails++; $display("FAIL t3_full: drops=%0d valid=%b model=%0d want 1/1/4", drop_count, m_word_valid, mq.size()); end
    for (int i = 0; i < 4; i++) idle(1);
    tests++; if (dut_pop.size() != 4 || m_word_valid !== 1'b0) begin
      fails++; $display("FAIL t3_drain: popped=%0d valid=%b want 4/0", dut_pop.size(), m_word_valid); end
    if (dut_pop.size() == 4) begin
      tests++; if (dut_pop[3] !== mk(1, 0, 1, 8'h00, 64'h0)) begin
        fails++; $display("FAIL t3_errword: got %h want err terminator", dut_pop[3]); end
      for (int i = 0; i < 3; i++) begin
        tests++; if (dut_pop[i] !== exp_pop[i]) begin
          fails++; $display("FAIL t3_word%0d: got %h want %h", i, dut_pop[i], exp_pop[i]); end
      end
    end
  endtask

  task automatic test_restart();
    do_reset();
    step(1, 1, 20, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 8'($urandom), 0, 0, 1);
    step(1, 1, 10, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 8'($urandom), 0, 0, 1);
    step(0, 0, 0, 0, 8'h00, 1, 1, 1);
    drain();
    tests++; if (drop_count !== 16'd1) begin fails++; $display("FAIL t4_drops: got %0d want 1", drop_count); end
    tests++; if (dut_pop.size() != 3) begin fails++; $display("FAIL t4_count: got %0d want 3", dut_pop.size()); end
    if (dut_pop.size() == 3) begin
      tests++; if (dut_pop[0] !== mk(1, 0, 1, 8'h00, 64'h0) || dut_pop[2][74:64] !== {3'b011, 8'h03}) begin
        fails++; $display("FAIL t4_shape: got %h .. %h want err then keep=03 last", dut_pop[0], dut_pop[2]); end
      for (int i = 1; i < 3; i++) begin
        tests++; if (dut_pop[i] !== exp_pop[i]) begin
          fails++; $display("FAIL t4_word%0d: got %h want %h", i, dut_pop[i], exp_pop[i]); end
      end
    end
  endtask

  task automatic test_overlen();
    do_reset();
    step(1, 1, 3, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 8'hA0 + 8'(i), 0, 0, 1);
    step(0, 0, 0, 1, 8'hA5, 1, 1, 1);
    // Second packet: the final in-range byte arrives together with fcs.
    step(1, 1, 9, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 8'h10 + 8'(i), 0, 0, 1);
    step(0, 0, 0, 1, 8'h77, 1, 0, 1);
    drain();
    tests++; if (dut_pop.size() != 3) begin fails++; $display("FAIL t5_count: got %0d want 3", dut_pop.size()); end
    if (dut_pop.size() == 3) begin
      tests++; if (dut_pop[0] !== mk(0, 1, 1, 8'h07, 64'h0000_0000_00A2A1A0)) begin
        fails++; $display("FAIL t5_short: got %h want %h", dut_pop[0], mk(0, 1, 1, 8'h07, 64'h00A2A1A0)); end
      tests++; if (dut_pop[2] !== mk(0, 0, 1, 8'h01, 64'h77) || dut_pop[1] !== exp_pop[1]) begin
        fails++; $display("FAIL t5_same_cycle: got %h %h want %h %h", dut_pop[1], dut_pop[2], exp_pop[1], mk(0, 0, 1, 8'h01, 64'h77)); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, 1, 20, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 8'($urandom), 0, 0, 0);
    tests++; if (m_word_valid !== 1'b1 || mq.size() != 2) begin
      fails++; $display("FAIL t6_queued: valid=%b model=%0d want 1/2", m_word_valid, mq.size()); end
    do_reset();
    tests++; if (m_word_valid !== 1'b0 || pkt_ongoing !== 1'b0 || m_word_keep !== 8'h00 || m_word_last !== 1'b0) begin
      fails++; $display("FAIL t6_cleared: valid=%b ongoing=%b keep=%h last=%b want all 0", m_word_valid, pkt_ongoing, m_word_keep, m_word_last); end
    step(1, 1, 4, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'h31 + 8'(i), 0, 0, 1);
    step(0, 0, 0, 0, 8'h00, 1, 1, 1);
    drain();
    tests++; if (dut_pop.size() != 1 || (dut_pop.size() == 1 && dut_pop[0] !== mk(0, 1, 1, 8'h0F, 64'h34333231))) begin
      fails++; $display("FAIL t6_fresh: count=%0d want single word keep=0F data=34333231", dut_pop.size()); end
  endtask

  task automatic test_random();
    do_reset();
    for (int p = 0; p < 80; p++) begin
      int len = $urandom_range(0, 30);
      int nb = len + $urandom_range(0, 3);
      int bias = ($urandom_range(0, 2) == 0) ? 10 : 85;
      bit hv = ($urandom_range(0, 15) != 0);
      bit restart = ($urandom_range(0, 9) == 0);
      bit joint = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) nb = nb / 2;
      step(1, hv, len, 0, 8'h00, 0, 0, $urandom_range(0, 99) < bias);
      for (int i = 0; i < nb; i++) begin
        bit last_b = (i == nb - 1) && joint && !restart;
        step(0, 0, 0, 1, 8'($urandom), last_b, 1'($urandom), $urandom_range(0, 99) < bias);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 99) < bias);
      end
      if (!restart && !(joint && nb > 0)) step(0, 0, 0, 0, 8'h00, 1, 1'($urandom), $urandom_range(0, 99) < bias);
    end
    step(0, 0, 0, 0, 8'h00, 1, 1, 1);
    drain();
    tests++; if (dut_pop.size() != exp_pop.size()) begin
      fails++; $display("FAIL rnd_count: got %0d words want %0d", dut_pop.size(), exp_pop.size()); end
    for (int i = 0; i < exp_pop.size() && i < dut_pop.size(); i++) begin
      tests++; if (dut_pop[i] !== exp_pop[i]) begin
        fails++; $display("FAIL rnd_word%0d: got %h want %h", i, dut_pop[i], exp_pop[i]); end
    end
    tests++; if (drop_count !== 16'(mdrops)) begin
      fails++; $display("FAIL rnd_drops: got %0d want %0d", drop_count, mdrops); end
  endtask

  initial begin
    test_reset();
    test_basic12();
    test_len16();
    test_backpressure();
    test_restart();
    test_overlen();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
